// File: rtl/reorder_buffer_mc.sv
// Parametrised in-order-commit reorder buffer: WB_PORTS writeback channels, COMMIT_W-wide
// retirement with store/redirect group termination, occupancy count and a two-phase flush.
module reorder_buffer_mc #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned OP_W     = 6,
  parameter int unsigned WB_PORTS = 3,
  parameter int unsigned COMMIT_W = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic                        iss_valid,
  input  logic [OP_W-1:0]             iss_op,
  input  logic [4:0]                  iss_dest,
  input  logic                        iss_is_st,
  output logic                        iss_ready,
  output logic [IDX_W-1:0]            iss_id,
  input  logic [WB_PORTS-1:0]         wb_valid,
  input  logic [WB_PORTS*IDX_W-1:0]   wb_id,
  input  logic [WB_PORTS*32-1:0]      wb_value,
  input  logic [WB_PORTS-1:0]         wb_redir,
  input  logic [WB_PORTS*32-1:0]      wb_topc,
  input  logic [2*IDX_W-1:0]          qry_id,
  output logic [1:0]                  qry_ready,
  output logic [63:0]                 qry_value,
  output logic [COMMIT_W-1:0]         cm_valid,
  output logic [COMMIT_W*5-1:0]       cm_dest,
  output logic [COMMIT_W*IDX_W-1:0]   cm_id,
  output logic [COMMIT_W*32-1:0]      cm_value,
  output logic                        st_valid,
  output logic [IDX_W-1:0]            st_id,
  output logic                        flush,
  output logic [31:0]                 flush_pc,
  output logic [IDX_W:0]              count
);

  localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);

  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;
  logic [DEPTH-1:0] ready_q, ready_d, redir_q, redir_d, is_st_q, is_st_d;
  logic [31:0]      value_q [DEPTH];
  logic [31:0]      value_d [DEPTH];
  logic [31:0]      topc_q  [DEPTH];
  logic [31:0]      topc_d  [DEPTH];
  logic [4:0]       dest_q  [DEPTH];
  logic [4:0]       dest_d  [DEPTH];

  logic [COMMIT_W-1:0]       cm_valid_q, cm_valid_d;
  logic [COMMIT_W*5-1:0]     cm_dest_q, cm_dest_d;
  logic [COMMIT_W*IDX_W-1:0] cm_id_q, cm_id_d;
  logic [COMMIT_W*32-1:0]    cm_value_q, cm_value_d;
  logic                      st_valid_q, st_valid_d;
  logic [IDX_W-1:0]          st_id_q, st_id_d;
  logic                      flush_q, flush_d;
  logic [31:0]               flush_pc_q, flush_pc_d;

  logic [IDX_W:0] retire_n;
  logic           iss_fire;
  logic           unused_op;

  assign unused_op = ^iss_op;

  function automatic logic occupied(input logic [IDX_W-1:0] id,
                                    input logic [IDX_W-1:0] head,
                                    input logic [IDX_W:0]   cnt);
    logic [IDX_W-1:0] off;
    off = id - head;
    return {1'b0, off} < cnt;
  endfunction

  assign iss_ready = (count_q != FULL) && !flush_q;
  assign iss_id    = tail_q;
  assign iss_fire  = iss_valid && iss_ready && rdy;

  always_comb begin
    qry_ready = '0;
    qry_value = '0;
    for (int unsigned r = 0; r < 2; r++) begin
      if (occupied(qry_id[r*IDX_W +: IDX_W], head_q, count_q) &&
          ready_q[qry_id[r*IDX_W +: IDX_W]]) begin
        qry_ready[r]          = 1'b1;
        qry_value[r*32 +: 32] = value_q[qry_id[r*IDX_W +: IDX_W]];
      end
    end
  end

  // Commit group: consecutive ready entries from head, closed after a store or a redirect.
  always_comb begin
    logic [IDX_W-1:0] slot;
    logic             stop;
    slot       = '0;
    stop       = 1'b0;
    retire_n   = '0;
    cm_valid_d = '0;
    cm_dest_d  = '0;
    cm_id_d    = '0;
    cm_value_d = '0;
    st_valid_d = 1'b0;
    st_id_d    = '0;
    flush_d    = flush_q;
    flush_pc_d = flush_pc_q;
    if (rdy) begin
      if (flush_q) begin
        flush_d = 1'b0;
      end else begin
        for (int unsigned j = 0; j < COMMIT_W; j++) begin
          slot = head_q + IDX_W'(j);
          if (!stop && ((IDX_W+1)'(j) < count_q) && ready_q[slot]) begin
            retire_n = retire_n + 1'b1;
            if (is_st_q[slot]) begin
              st_valid_d = 1'b1;
              st_id_d    = slot;
              stop       = 1'b1;
            end else begin
              cm_valid_d[j]              = 1'b1;
              cm_dest_d[j*5 +: 5]        = dest_q[slot];
              cm_id_d[j*IDX_W +: IDX_W]  = slot;
              cm_value_d[j*32 +: 32]     = value_q[slot];
            end
            if (redir_q[slot]) begin
              flush_d    = 1'b1;
              flush_pc_d = topc_q[slot];
              stop       = 1'b1;
            end
          end else begin
            stop = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    logic [IDX_W-1:0] wid;
    wid     = '0;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ready_d = ready_q;
    redir_d = redir_q;
    is_st_d = is_st_q;
    value_d = value_q;
    topc_d  = topc_q;
    dest_d  = dest_q;
    if (rdy) begin
      if (flush_q) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
        ready_d = '0;
        redir_d = '0;
      end else begin
        // Ascending channel order lets the highest channel win on a shared id.
        for (int unsigned k = 0; k < WB_PORTS; k++) begin
          wid = wb_id[k*IDX_W +: IDX_W];
          if (wb_valid[k] && occupied(wid, head_q, count_q) && !(iss_fire && wid == tail_q)) begin
            ready_d[wid] = 1'b1;
            redir_d[wid] = wb_redir[k];
            value_d[wid] = wb_value[k*32 +: 32];
            topc_d[wid]  = wb_topc[k*32 +: 32];
          end
        end
        if (iss_fire) begin
          ready_d[tail_q] = 1'b0;
          redir_d[tail_q] = 1'b0;
          is_st_d[tail_q] = iss_is_st;
          dest_d[tail_q]  = iss_dest;
          tail_d          = tail_q + 1'b1;
        end
        head_d  = head_q + retire_n[IDX_W-1:0];
        count_d = count_q + (IDX_W+1)'(iss_fire) - retire_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ready_q    <= '0;
      redir_q    <= '0;
      is_st_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        value_q[i] <= '0;
        topc_q[i]  <= '0;
        dest_q[i]  <= '0;
      end
      cm_valid_q <= '0;
      cm_dest_q  <= '0;
      cm_id_q    <= '0;
      cm_value_q <= '0;
      st_valid_q <= 1'b0;
      st_id_q    <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ready_q    <= ready_d;
      redir_q    <= redir_d;
      is_st_q    <= is_st_d;
      value_q    <= value_d;
      topc_q     <= topc_d;
      dest_q     <= dest_d;
      cm_valid_q <= cm_valid_d;
      cm_dest_q  <= cm_dest_d;
      cm_id_q    <= cm_id_d;
      cm_value_q <= cm_value_d;
      st_valid_q <= st_valid_d;
      st_id_q    <= st_id_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  assign cm_valid = cm_valid_q;
  assign cm_dest  = cm_dest_q;
  assign cm_id    = cm_id_q;
  assign cm_value = cm_value_q;
  assign st_valid = st_valid_q;
  assign st_id    = st_id_q;
  assign flush    = flush_q;
  assign flush_pc = flush_pc_q;
  assign count    = count_q;

endmodule

// File: tb/tb_reorder_buffer_mc.sv
// Bench for reorder_buffer_mc: table vectors, directed corner sequences and random traffic
// checked against a queue-based model of the in-order commit rules.
module tb_reorder_buffer_mc;

  logic        clk, rst, rdy;
  logic        iss_valid, iss_is_st, iss_ready;
  logic [5:0]  iss_op;
  logic [4:0]  iss_dest;
  logic [3:0]  iss_id;
  logic [2:0]  wb_valid, wb_redir;
  logic [11:0] wb_id;
  logic [95:0] wb_value, wb_topc;
  logic [7:0]  qry_id;
  logic [1:0]  qry_ready;
  logic [63:0] qry_value;
  logic [1:0]  cm_valid;
  logic [9:0]  cm_dest;
  logic [7:0]  cm_id;
  logic [63:0] cm_value;
  logic        st_valid, flush;
  logic [3:0]  st_id;
  logic [31:0] flush_pc;
  logic [4:0]  count;

  reorder_buffer_mc #(.DEPTH(16), .IDX_W(4), .OP_W(6), .WB_PORTS(3), .COMMIT_W(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .iss_valid(iss_valid), .iss_op(iss_op), .iss_dest(iss_dest), .iss_is_st(iss_is_st),
    .iss_ready(iss_ready), .iss_id(iss_id),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value), .wb_redir(wb_redir), .wb_topc(wb_topc),
    .qry_id(qry_id), .qry_ready(qry_ready), .qry_value(qry_value),
    .cm_valid(cm_valid), .cm_dest(cm_dest), .cm_id(cm_id), .cm_value(cm_value),
    .st_valid(st_valid), .st_id(st_id), .flush(flush), .flush_pc(flush_pc), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the ROB is an ordered list of live entries, oldest first.
  typedef struct {
    int          id;
    logic [4:0]  dest;
    bit          st;
    bit          rdy;
    logic [31:0] val;
    bit          redir;
    logic [31:0] topc;
  } ent_t;

  ent_t        m_rob[$];
  int          m_tail;
  bit          m_flush;
  logic [31:0] m_fpc;
  bit   [1:0]  m_cmv;
  logic [4:0]  m_cmd[2];
  int          m_cmi[2];
  logic [31:0] m_cmval[2];
  bit          m_st;
  int          m_st_id;

  task automatic model_step();
    int n;
    m_cmv = '0;
    m_st  = 0;
    if (rst) begin
      m_rob.delete();
      m_tail  = 0;
      m_flush = 0;
      m_fpc   = '0;
    end else if (rdy) begin
      if (m_flush) begin
        m_rob.delete();
        m_tail  = 0;
        m_flush = 0;
      end else begin
        n = 0;
        for (int j = 0; j < 2; j++) begin
          if (j >= m_rob.size() || !m_rob[j].rdy) break;
          n++;
          if (m_rob[j].st) begin
            m_st = 1; m_st_id = m_rob[j].id;
          end else begin
            m_cmv[j] = 1; m_cmd[j] = m_rob[j].dest; m_cmi[j] = m_rob[j].id; m_cmval[j] = m_rob[j].val;
          end
          if (m_rob[j].redir) begin
            m_flush = 1; m_fpc = m_rob[j].topc;
          end
          if (m_rob[j].st || m_rob[j].redir) break;
        end
        for (int k = 0; k < 3; k++) begin
          if (wb_valid[k]) begin
            foreach (m_rob[i]) begin
              if (m_rob[i].id == int'(wb_id[k*4 +: 4])) begin
                m_rob[i].rdy   = 1;
                m_rob[i].val   = wb_value[k*32 +: 32];
                m_rob[i].redir = wb_redir[k];
                m_rob[i].topc  = wb_topc[k*32 +: 32];
              end
            end
          end
        end
        if (iss_valid && m_rob.size() < 16) begin
          m_rob.push_back('{id: m_tail, dest: iss_dest, st: iss_is_st, rdy: 0, val: '0, redir: 0, topc: '0});
          m_tail = (m_tail + 1) % 16;
        end
        repeat (n) void'(m_rob.pop_front());
      end
    end
  endtask

  task automatic model_qry(input logic [3:0] id, output bit r, output logic [31:0] v);
    r = 0; v = '0;
    foreach (m_rob[i]) begin
      if (m_rob[i].id == int'(id) && m_rob[i].rdy) begin
        r = 1; v = m_rob[i].val;
      end
    end
  endtask

  task automatic clr_in();
    rst = 0; rdy = 1; iss_valid = 0; iss_op = '0; iss_dest = '0; iss_is_st = 0;
    wb_valid = '0; wb_id = '0; wb_value = '0; wb_redir = '0; wb_topc = '0; qry_id = '0;
  endtask

  task automatic set_wb(input int k, input logic [3:0] id, input logic [31:0] val,
                        input bit rd, input logic [31:0] pc);
    wb_valid[k]         = 1'b1;
    wb_id[k*4 +: 4]     = id;
    wb_value[k*32 +: 32] = val;
    wb_redir[k]         = rd;
    wb_topc[k*32 +: 32] = pc;
  endtask

  // One cycle: check combinational outputs against the model, clock, check registered outputs.
  task automatic tick();
    bit          qr;
    logic [31:0] qv;
    #1;
    chk("iss_ready", iss_ready, (m_rob.size() < 16) && !m_flush);
    chk("iss_id", iss_id, m_tail);
    for (int r = 0; r < 2; r++) begin
      model_qry(qry_id[r*4 +: 4], qr, qv);
      chk("qry_ready", qry_ready[r], qr);
      chk("qry_value", qry_value[r*32 +: 32], qv);
    end
    model_step();
    @(posedge clk);
    #1;
    chk("count", count, m_rob.size());
    chk("flush", flush, m_flush);
    chk("flush_pc", flush_pc, m_fpc);
    chk("st_valid", st_valid, m_st);
    if (m_st) chk("st_id", st_id, m_st_id);
    chk("cm_valid", cm_valid, m_cmv);
    for (int j = 0; j < 2; j++) begin
      if (m_cmv[j]) begin
        chk("cm_dest", cm_dest[j*5 +: 5], m_cmd[j]);
        chk("cm_id", cm_id[j*4 +: 4], m_cmi[j]);
        chk("cm_value", cm_value[j*32 +: 32], m_cmval[j]);
      end
    end
  endtask

  task automatic do_reset();
    clr_in();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  typedef struct {
    bit       rst;
    bit       iv;
    bit       ist;
    bit [2:0] wv;
    bit [3:0] wid;
    bit [1:0] ecv;
    bit [3:0] eid0;
    bit [3:0] eid1;
    bit       est;
    bit [3:0] esid;
    int       ecnt;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1, 0, 0, 3'b000, 4'd0, 2'b00, 4'd0, 4'd0, 0, 4'd0, 0};
    vecs[1]  = '{0, 1, 0, 3'b000, 4'd0, 2'b00, 4'd0, 4'd0, 0, 4'd0, 1};
    vecs[2]  = '{0, 1, 0, 3'b000, 4'd0, 2'b00, 4'd0, 4'd0, 0, 4'd0, 2};
    vecs[3]  = '{0, 0, 0, 3'b001, 4'd1, 2'b00, 4'd0, 4'd0, 0, 4'd0, 2};
    vecs[4]  = '{0, 0, 0, 3'b001, 4'd0, 2'b00, 4'd0, 4'd0, 0, 4'd0, 2};
    vecs[5]  = '{0, 0, 0, 3'b000, 4'd0, 2'b11, 4'd0, 4'd1, 0, 4'd0, 0};
    vecs[6]  = '{1, 0, 0, 3'b000, 4'd0, 2'b00, 4'd0, 4'd0, 0, 4'd0, 0};
    vecs[7]  = '{0, 1, 1, 3'b000, 4'd0, 2'b00, 4'd0, 4'd0, 0, 4'd0, 1};
    vecs[8]  = '{0, 1, 0, 3'b000, 4'd0, 2'b00, 4'd0, 4'd0, 0, 4'd0, 2};
    vecs[9]  = '{0, 0, 0, 3'b001, 4'd1, 2'b00, 4'd0, 4'd0, 0, 4'd0, 2};
    vecs[10] = '{0, 0, 0, 3'b100, 4'd0, 2'b00, 4'd0, 4'd0, 0, 4'd0, 2};
    vecs[11] = '{0, 0, 0, 3'b000, 4'd0, 2'b00, 4'd0, 4'd0, 1, 4'd0, 1};
    vecs[12] = '{0, 0, 0, 3'b000, 4'd0, 2'b01, 4'd1, 4'd0, 0, 4'd0, 0};

    clr_in();
    m_tail = 0; m_flush = 0; m_fpc = '0; m_cmv = '0; m_st = 0;
    do_reset();
    chk("reset_count", count, 0);
    chk("reset_flush_pc", flush_pc, 0);
    chk("reset_iss_ready", iss_ready, 1);

    // Table vectors: in-order dual commit and store-terminated group.
    for (int i = 0; i < 13; i++) begin
      clr_in();
      rst = vecs[i].rst; iss_valid = vecs[i].iv; iss_is_st = vecs[i].ist; iss_dest = 5'(i + 1);
      for (int k = 0; k < 3; k++)
        if (vecs[i].wv[k]) set_wb(k, vecs[i].wid, 32'h100 + 32'(vecs[i].wid), 0, 0);
      tick();
      chk("vec_cm_valid", cm_valid, vecs[i].ecv);
      chk("vec_st_valid", st_valid, vecs[i].est);
      chk("vec_count", count, vecs[i].ecnt);
      if (vecs[i].ecv[0]) chk("vec_cm_id0", cm_id[3:0], vecs[i].eid0);
      if (vecs[i].ecv[1]) chk("vec_cm_id1", cm_id[7:4], vecs[i].eid1);
      if (vecs[i].est) chk("vec_st_id", st_id, vecs[i].esid);
    end

    // Fill to DEPTH; the extra request must be refused.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      clr_in(); iss_valid = 1; iss_dest = 5'(i); tick();
    end
    chk("full_count", count, 16);
    chk("full_iss_ready", iss_ready, 0);
    clr_in(); iss_valid = 1; tick();
    chk("full_tail_hold", iss_id, 0);
    chk("full_count_hold", count, 16);

    // Redirect: ids 2,3 retire together, flush pulse, younger id4 never commits.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      clr_in(); iss_valid = 1; iss_dest = 5'(i + 3); tick();
    end
    clr_in(); set_wb(0, 4'd0, 32'hA0, 0, 0); set_wb(1, 4'd1, 32'hA1, 0, 0); set_wb(2, 4'd2, 32'hA2, 0, 0); tick();
    clr_in(); set_wb(0, 4'd3, 32'hA3, 1, 32'h1040); set_wb(1, 4'd4, 32'hA4, 0, 0); tick();
    chk("redir_pre_cm", cm_valid, 2'b11);
    clr_in(); tick();
    chk("redir_cm_valid", cm_valid, 2'b11);
    chk("redir_cm_id1", cm_id[7:4], 3);
    chk("redir_flush", flush, 1);
    chk("redir_flush_pc", flush_pc, 32'h1040);
    chk("redir_iss_ready", iss_ready, 0);
    clr_in(); iss_valid = 1; tick();
    chk("post_flush", flush, 0);
    chk("post_count", count, 0);
    chk("post_cm_valid", cm_valid, 0);
    chk("post_iss_ready", iss_ready, 1);

    // Wrap: 30 single issue/retire rounds.
    do_reset();
    for (int i = 0; i < 30; i++) begin
      chk("wrap_iss_id", iss_id, i % 16);
      clr_in(); iss_valid = 1; iss_dest = 5'd9; tick();
      clr_in(); set_wb(1, 4'(i % 16), 32'(i), 0, 0); tick();
      clr_in(); tick();
      chk("wrap_cm_valid", cm_valid, 2'b01);
      chk("wrap_cm_id", cm_id[3:0], i % 16);
      chk("wrap_cm_value", cm_value[31:0], i);
    end

    // Same-id writeback on two channels, then a stall over a ready head.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      clr_in(); iss_valid = 1; iss_dest = 5'(i); tick();
    end
    clr_in(); set_wb(0, 4'd5, 32'd7, 0, 0); set_wb(2, 4'd5, 32'd9, 0, 0); tick();
    qry_id = {4'd0, 4'd5};
    #1;
    chk("qry_hi_wins_rdy", qry_ready, 2'b01);
    chk("qry_hi_wins_val", qry_value[31:0], 32'd9);
    clr_in(); set_wb(1, 4'd0, 32'h55, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      clr_in(); rdy = 0; tick();
      chk("stall_cm_valid", cm_valid, 0);
      chk("stall_count", count, 6);
    end
    clr_in(); tick();
    chk("unstall_cm_valid", cm_valid, 2'b01);
    chk("unstall_cm_value", cm_value[31:0], 32'h55);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 900; c++) begin
      clr_in();
      rst       = ($urandom_range(299) == 0);
      rdy       = ($urandom_range(7) != 0);
      iss_valid = ($urandom_range(9) < 6);
      iss_op    = 6'($urandom);
      iss_dest  = 5'($urandom);
      iss_is_st = ($urandom_range(4) == 0);
      qry_id    = 8'($urandom);
      if ((c % 200) >= 40) begin
        for (int k = 0; k < 3; k++) begin
          if ($urandom_range(2) != 0) begin
            logic [3:0] id;
            if (m_rob.size() > 0 && $urandom_range(5) != 0)
              id = 4'(m_rob[$urandom_range(m_rob.size() - 1)].id);
            else
              id = 4'($urandom_range(15));
            set_wb(k, id, $urandom, ($urandom_range(19) == 0), $urandom);
          end
        end
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
